irq_exc_ctrl: RTL and testbench
===============================

# irq_exc_ctrl

Parametrised interrupt/exception controller for the pipelined MIPS core. It replaces the single combinational `IRQ && ~ker` term in the decoder with the following state:
- N edge-latched, individually enabled interrupt lines with fixed priority;
- undefined-instruction trapping;
- a USER/KERNEL mode register, EPC and cause capture;
- an `eret` return handshake.

Sits beside the ID stage: it consumes the decoded ID instruction and drives flush and PC-vector selection to the PC mux.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of interrupt lines, 1..16.
- `PC_WIDTH`, 32: PC/EPC width.
- `VEC_IRQ`, 32'h8000_0004: interrupt handler address.
- `VEC_EXC`, 32'h8000_0008: exception handler address.

Ports (one clock; reset is asynchronous and active-low, named `reset`):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `irq`  in  NUM_IRQ  raw interrupt request levels.
- `id_valid`  in  1  ID holds a real instruction (not a bubble).
- `id_pc`  in  PC_WIDTH  PC of the ID instruction.
- `stall`  in  1  ID stalled; no take or return this cycle.
- `undef`  in  1  ID instruction is undefined.
- `eret`  in  1  ID instruction is exception return.
- `en_wr`  in  1  write the enable register.
- `en_din`  in  NUM_IRQ  new enable value.
- `take_irq`  out  1  interrupt taken this cycle.
- `take_exc`  out  1  exception taken this cycle.
- `ret`  out  1  eret accepted this cycle.
- `flush`  out  1  `take_irq|take_exc|ret`.
- `vector`  out  PC_WIDTH  next PC when `flush` is high.
- `epc`  out  PC_WIDTH  saved return PC.
- `cause`  out  8  last cause code.
- `ker`  out  1  kernel mode.
- `pending`  out  NUM_IRQ  latched requests.

## Operation
- Mode FSM has two states, USER and KERNEL; `ker` = (state==KERNEL).
- `go` = `id_valid & ~stall`.
- Edge detect: `pending[i]` sets on a 0→1 transition of `irq[i]` (as seen after the optional synchronizer). It clears on the edge where line i is taken. If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Eligible lines = `pending & en`. The lowest index has highest priority; `sel` is that index.
- `take_exc` = USER & `go` & `undef`. Exceptions beat interrupts.
- `take_irq` = USER & `go` & ~`undef` & (eligible ≠ 0).
- `ret` = KERNEL & `go` & `eret`.
- An `eret` in USER is a NOP, as is an `undef` in KERNEL (no take, no state change).
- IRQs arriving in KERNEL stay pending and are taken after the return.
- On the `take_exc` edge: `epc` ← `id_pc`+4; `cause` ← 8'h01; state ← KERNEL.
- On the `take_irq` edge: `epc` ← `id_pc` (instruction re-executes); `cause` ← 8'h80|`sel`; `pending[sel]` ← 0; state ← KERNEL.
- On the `ret` edge: state ← USER. `epc` and `cause` hold.
- `vector`: `VEC_EXC` if `take_exc`, `VEC_IRQ` if `take_irq`, `epc` if `ret`, else 0.
- `en_wr` loads `en` on the edge and takes effect in the following cycle. It may occur in any state.
- All outputs except the registers are combinational from registers and current inputs.

## Timing
- Reset (async, `reset`=0): state USER, `pending` 0, `en` all ones, `epc` 0, `cause` 0. All pulse outputs are 0 while in reset.
- Without sync: an `irq` rise sampled at edge k sets `pending` at edge k. `take_irq` can be high in the cycle after edge k.
- With sync: the same rise sets `pending` at edge k+2.
- `take_*`/`ret` are single-cycle whenever `go` is true. Under `stall` they stay low and are re-evaluated every cycle.
- `ret` and `take_irq` are mutually exclusive by state. The earliest re-entry after `ret` is the next cycle.
- Reset mid-handler returns to USER and discards pending requests.

## Configuration
- `IRQ_SYNC_EN` defined: each `irq` bit passes through a two-flop synchronizer before edge detection, adding 2 cycles of latency. Use when lines are asynchronous.
- `IRQ_SYNC_EN` undefined: `irq` is treated as synchronous to `clk` and edge-detected directly.

## Test plan
- Reset, `irq`=4'b0001 rise, `id_valid`=1, `id_pc`=0x100 → `take_irq`=1, `vector`=0x80000004, then `epc`=0x100, `cause`=0x80, `ker`=1, `pending`=0.
- `irq` 4'b1010 rising together → line 1 taken (`cause`=0x81); after `ret`, line 3 taken (`cause`=0x83).
- USER, `undef`=1, `id_pc`=0x200, with `irq[0]` also pending → `take_exc`, `vector`=0x80000008, `epc`=0x204, `cause`=0x01, `pending[0]` still 1.
- KERNEL, `stall`=1 with `eret`=1 for 3 cycles → `ret`=0; `stall` drops → `ret`=1, `vector`=`epc`, `ker`=0 next cycle.
- `en_din`=4'b1110 written, `irq[0]` rises → no take, `pending[0]`=1; re-enable → taken the cycle after `en` updates.
- `take_irq` on line 2 coincident with a new `irq[2]` rise → `pending[2]` stays 1; assert `reset` in KERNEL → `ker`=0 and `pending`=0 immediately.

Source files
------------

// File: rtl/irq_exc_ctrl.sv
`timescale 1ns/1ps
// irq_exc_ctrl: interrupt/exception controller for the pipelined MIPS core.
// Edge-latched, individually enabled IRQ lines with fixed priority (lowest
// index wins), undefined-instruction trap, USER/KERNEL mode, EPC/cause
// capture and eret return. Sits beside ID and drives flush/vector to the PC mux.
// Optional feature: define IRQ_SYNC_EN to pass each irq bit through a two-flop
// synchronizer before edge detection (adds 2 cycles of latency).
module irq_exc_ctrl #(
  parameter int                    NUM_IRQ  = 4,
  parameter int                    PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   VEC_IRQ  = 32'h8000_0004,
  parameter logic [PC_WIDTH-1:0]   VEC_EXC  = 32'h8000_0008
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                id_valid,
  input  logic [PC_WIDTH-1:0] id_pc,
  input  logic                stall,
  input  logic                undef,
  input  logic                eret,
  input  logic                en_wr,
  input  logic [NUM_IRQ-1:0]  en_din,
  output logic                take_irq,
  output logic                take_exc,
  output logic                ret,
  output logic                flush,
  output logic [PC_WIDTH-1:0] vector,
  output logic [PC_WIDTH-1:0] epc,
  output logic [7:0]          cause,
  output logic                ker,
  output logic [NUM_IRQ-1:0]  pending
);

  typedef enum logic {ST_USER = 1'b0, ST_KERNEL = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_IRQ-1:0]   r_pending;
  logic [NUM_IRQ-1:0]   r_en;
  logic [NUM_IRQ-1:0]   r_irq_prev;
  logic [PC_WIDTH-1:0]  r_epc;
  logic [7:0]           r_cause;

  logic [NUM_IRQ-1:0]   w_irq_lvl;
  logic [NUM_IRQ-1:0]   w_rise;
  logic [NUM_IRQ-1:0]   w_elig;
  logic [NUM_IRQ-1:0]   w_clr;
  logic [3:0]           w_sel;
  logic                 w_go;
  logic                 w_take_irq;
  logic                 w_take_exc;
  logic                 w_ret;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0]   r_sync1;
  logic [NUM_IRQ-1:0]   r_sync2;

  // Two-flop synchronizer for asynchronous interrupt lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_lvl = r_sync2;
`else
  assign w_irq_lvl = irq;
`endif

  // Remember the previous level of each line for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_irq_prev <= '0;
    else        r_irq_prev <= w_irq_lvl;
  end

  assign w_rise = w_irq_lvl & ~r_irq_prev;
  assign w_elig = r_pending & r_en;

  // Priority encoder: lowest eligible index wins
  always_comb begin
    w_sel = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = 4'(i);
    end
  end

  // Gating go with reset keeps every pulse output low while reset is held
  assign w_go = id_valid & ~stall & reset;

  // Mode state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_USER;
    else        r_state <= w_state_nxt;
  end

  // Next-state: enter KERNEL on any take, leave it on an accepted eret
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_USER:   if (w_take_exc || w_take_irq) w_state_nxt = ST_KERNEL;
      ST_KERNEL: if (w_ret) w_state_nxt = ST_USER;
      default:   w_state_nxt = ST_USER;
    endcase
  end

  // Mode-dependent pulse outputs; exceptions beat interrupts, eret/undef
  // are NOPs in the wrong mode
  always_comb begin
    w_take_exc = 1'b0;
    w_take_irq = 1'b0;
    w_ret      = 1'b0;
    case (r_state)
      ST_USER: begin
        w_take_exc = w_go & undef;
        w_take_irq = w_go & ~undef & (|w_elig);
      end
      ST_KERNEL: w_ret = w_go & eret;
      default: ;
    endcase
  end

  // Only the taken line is cleared; a simultaneous new rise re-sets it
  assign w_clr = w_take_irq ? (NUM_IRQ'(1) << w_sel) : '0;

  // Pending request latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_rise;
  end

  // Enable register; a write takes effect from the next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_en <= '1;
    else if (en_wr) r_en <= en_din;
  end

  // EPC and cause capture; an exception resumes after the faulting
  // instruction, an interrupt re-executes the interrupted one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epc   <= '0;
      r_cause <= 8'h00;
    end else if (w_take_exc) begin
      r_epc   <= id_pc + PC_WIDTH'(4);
      r_cause <= 8'h01;
    end else if (w_take_irq) begin
      r_epc   <= id_pc;
      r_cause <= {4'h8, w_sel};
    end
  end

  // Next-PC vector for the PC mux
  always_comb begin
    vector = '0;
    if (w_take_exc)      vector = VEC_EXC;
    else if (w_take_irq) vector = VEC_IRQ;
    else if (w_ret)      vector = r_epc;
  end

  assign take_irq = w_take_irq;
  assign take_exc = w_take_exc;
  assign ret      = w_ret;
  assign flush    = w_take_irq | w_take_exc | w_ret;
  assign epc      = r_epc;
  assign cause    = r_cause;
  assign ker      = (r_state == ST_KERNEL);
  assign pending  = r_pending;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
`timescale 1ns/1ps
// Bench for irq_exc_ctrl (default build): directed vector table, a reset
// sequence, and randomized stimulus against a behavioural model.
module tb_irq_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        stall, undef, eret, en_wr;
  logic [3:0]  en_din;
  logic        take_irq, take_exc, ret, flush, ker;
  logic [31:0] vector, epc;
  logic [7:0]  cause;
  logic [3:0]  pending;

  int n_chk  = 0;
  int n_fail = 0;

  irq_exc_ctrl #(.NUM_IRQ(4), .PC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .irq(irq), .id_valid(id_valid), .id_pc(id_pc),
    .stall(stall), .undef(undef), .eret(eret), .en_wr(en_wr), .en_din(en_din),
    .take_irq(take_irq), .take_exc(take_exc), .ret(ret), .flush(flush),
    .vector(vector), .epc(epc), .cause(cause), .ker(ker), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq; logic v; logic [31:0] pc; logic st, un, er, ew; logic [3:0] ed;
    logic ti, te, rt; logic [31:0] vec;
    logic k; logic [3:0] pend; logic [31:0] epc; logic [7:0] cause;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic [3:0] i, logic v, logic [31:0] pc, logic st, logic un,
                              logic er, logic ew, logic [3:0] ed, logic ti, logic te,
                              logic rt, logic [31:0] vec, logic k, logic [3:0] pend,
                              logic [31:0] e, logic [7:0] c);
    vec_t r;
    r.irq = i; r.v = v; r.pc = pc; r.st = st; r.un = un; r.er = er; r.ew = ew; r.ed = ed;
    r.ti = ti; r.te = te; r.rt = rt; r.vec = vec;
    r.k = k; r.pend = pend; r.epc = e; r.cause = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] i, input logic v, input logic [31:0] pc,
                       input logic st, input logic un, input logic er,
                       input logic ew, input logic [3:0] ed);
    irq = i; id_valid = v; id_pc = pc; stall = st; undef = un; eret = er;
    en_wr = ew; en_din = ed;
  endtask

  // Behavioural reference state
  logic        m_ker;
  logic [3:0]  m_pend, m_en, m_prev;
  logic [31:0] m_epc;
  logic [7:0]  m_cause;

  task automatic model_reset();
    m_ker = 0; m_pend = 0; m_en = 4'hF; m_prev = 0; m_epc = 0; m_cause = 0;
  endtask

  initial begin
    logic        go, e_ti, e_te, e_rt;
    logic [3:0]  elig, low, rise;
    logic [31:0] e_vec;
    int          sel;

    // Directed vectors: inputs, expected pulses, expected state after the edge
    tbl[0]  = mk(4'b0001,1,32'h100,0,0,0,0,0, 0,0,0,0,            0,4'b0001,32'h0,  8'h00);
    tbl[1]  = mk(4'b0001,1,32'h100,0,0,0,0,0, 1,0,0,32'h80000004, 1,4'b0000,32'h100,8'h80);
    tbl[2]  = mk(4'b0000,1,32'h104,0,0,1,0,0, 0,0,1,32'h100,      0,4'b0000,32'h100,8'h80);
    tbl[3]  = mk(4'b1010,0,32'h0,  0,0,0,0,0, 0,0,0,0,            0,4'b1010,32'h100,8'h80);
    tbl[4]  = mk(4'b1010,1,32'h120,0,0,0,0,0, 1,0,0,32'h80000004, 1,4'b1000,32'h120,8'h81);
    tbl[5]  = mk(4'b1010,1,32'h300,0,0,1,0,0, 0,0,1,32'h120,      0,4'b1000,32'h120,8'h81);
    tbl[6]  = mk(4'b1010,1,32'h124,0,0,0,0,0, 1,0,0,32'h80000004, 1,4'b0000,32'h124,8'h83);
    tbl[7]  = mk(4'b1010,1,32'h400,0,0,1,0,0, 0,0,1,32'h124,      0,4'b0000,32'h124,8'h83);
    tbl[8]  = mk(4'b1011,0,32'h0,  0,0,0,0,0, 0,0,0,0,            0,4'b0001,32'h124,8'h83);
    tbl[9]  = mk(4'b1011,1,32'h200,0,1,0,0,0, 0,1,0,32'h80000008, 1,4'b0001,32'h204,8'h01);
    tbl[10] = mk(4'b1011,1,32'h500,1,0,1,0,0, 0,0,0,0,            1,4'b0001,32'h204,8'h01);
    tbl[11] = mk(4'b1011,1,32'h500,1,0,1,0,0, 0,0,0,0,            1,4'b0001,32'h204,8'h01);
    tbl[12] = mk(4'b1011,1,32'h500,1,0,1,0,0, 0,0,0,0,            1,4'b0001,32'h204,8'h01);
    tbl[13] = mk(4'b1011,1,32'h600,0,1,0,0,0, 0,0,0,0,            1,4'b0001,32'h204,8'h01);
    tbl[14] = mk(4'b1011,1,32'h604,0,0,1,0,0, 0,0,1,32'h204,      0,4'b0001,32'h204,8'h01);
    tbl[15] = mk(4'b1011,1,32'h700,0,0,0,0,0, 1,0,0,32'h80000004, 1,4'b0000,32'h700,8'h80);
    tbl[16] = mk(4'b1011,1,32'h704,0,0,1,0,0, 0,0,1,32'h700,      0,4'b0000,32'h700,8'h80);
    tbl[17] = mk(4'b0000,0,32'h0,  0,0,0,1,4'b1110, 0,0,0,0,      0,4'b0000,32'h700,8'h80);
    tbl[18] = mk(4'b0001,1,32'h800,0,0,0,0,0, 0,0,0,0,            0,4'b0001,32'h700,8'h80);
    tbl[19] = mk(4'b0001,1,32'h804,0,0,0,0,0, 0,0,0,0,            0,4'b0001,32'h700,8'h80);
    tbl[20] = mk(4'b0001,1,32'h808,0,0,0,1,4'b1111, 0,0,0,0,      0,4'b0001,32'h700,8'h80);
    tbl[21] = mk(4'b0001,1,32'h80C,0,0,0,0,0, 1,0,0,32'h80000004, 1,4'b0000,32'h80C,8'h80);
    tbl[22] = mk(4'b0001,1,32'h810,0,0,1,0,0, 0,0,1,32'h80C,      0,4'b0000,32'h80C,8'h80);
    tbl[23] = mk(4'b0101,0,32'h0,  0,0,0,0,0, 0,0,0,0,            0,4'b0100,32'h80C,8'h80);
    tbl[24] = mk(4'b0001,0,32'h0,  0,0,0,0,0, 0,0,0,0,            0,4'b0100,32'h80C,8'h80);
    tbl[25] = mk(4'b0101,1,32'h900,0,0,0,0,0, 1,0,0,32'h80000004, 1,4'b0100,32'h900,8'h82);

    // Reset state, with an undefined instruction presented to show pulses stay low
    reset = 1'b0;
    drive(4'b0000, 1, 32'h0, 0, 1, 0, 0, 4'b0000);
    repeat (2) @(negedge clk);
    chk("rst_ker",     {31'b0, ker},      32'h0);
    chk("rst_pending", {28'b0, pending},  32'h0);
    chk("rst_epc",     epc,               32'h0);
    chk("rst_cause",   {24'b0, cause},    32'h0);
    chk("rst_take_exc", {31'b0, take_exc}, 32'h0);
    chk("rst_flush",   {31'b0, flush},    32'h0);
    drive(4'b0000, 0, 32'h0, 0, 0, 0, 0, 4'b0000);
    reset = 1'b1;

    for (int r = 0; r < 26; r++) begin
      @(negedge clk);
      drive(tbl[r].irq, tbl[r].v, tbl[r].pc, tbl[r].st, tbl[r].un, tbl[r].er,
            tbl[r].ew, tbl[r].ed);
      #1;
      chk($sformatf("row%0d_take_irq", r), {31'b0, take_irq}, {31'b0, tbl[r].ti});
      chk($sformatf("row%0d_take_exc", r), {31'b0, take_exc}, {31'b0, tbl[r].te});
      chk($sformatf("row%0d_ret", r),      {31'b0, ret},      {31'b0, tbl[r].rt});
      chk($sformatf("row%0d_flush", r),    {31'b0, flush},
          {31'b0, tbl[r].ti | tbl[r].te | tbl[r].rt});
      chk($sformatf("row%0d_vector", r),   vector, tbl[r].vec);
      @(posedge clk); #1;
      chk($sformatf("row%0d_ker", r),     {31'b0, ker},     {31'b0, tbl[r].k});
      chk($sformatf("row%0d_pending", r), {28'b0, pending}, {28'b0, tbl[r].pend});
      chk($sformatf("row%0d_epc", r),     epc,              tbl[r].epc);
      chk($sformatf("row%0d_cause", r),   {24'b0, cause},   {24'b0, tbl[r].cause});
    end

    // Reset asserted mid-handler: immediate return to USER, pending discarded
    @(negedge clk);
    drive(4'b0101, 1, 32'h0, 0, 1, 0, 0, 4'b0000);
    reset = 1'b0;
    #1;
    chk("midrst_ker",      {31'b0, ker},      32'h0);
    chk("midrst_pending",  {28'b0, pending},  32'h0);
    chk("midrst_take_exc", {31'b0, take_exc}, 32'h0);
    @(negedge clk);
    drive(4'b0000, 0, 32'h0, 0, 0, 0, 0, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Randomized stimulus against the behavioural model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive(4'($urandom), $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, 4'($urandom));
      go   = id_valid & ~stall;
      elig = m_pend & m_en;
      low  = elig & (~elig + 4'd1);
      sel  = $clog2(low);
      e_te = !m_ker && go && undef;
      e_ti = !m_ker && go && !undef && (elig != 0);
      e_rt = m_ker && go && eret;
      e_vec = e_te ? 32'h80000008 : e_ti ? 32'h80000004 : e_rt ? m_epc : 32'h0;
      #1;
      chk("rnd_take_irq", {31'b0, take_irq}, {31'b0, e_ti});
      chk("rnd_take_exc", {31'b0, take_exc}, {31'b0, e_te});
      chk("rnd_ret",      {31'b0, ret},      {31'b0, e_rt});
      chk("rnd_flush",    {31'b0, flush},    {31'b0, e_ti | e_te | e_rt});
      chk("rnd_vector",   vector,            e_vec);
      // Model update at the clock edge
      rise = irq & ~m_prev;
      m_prev = irq;
      if (e_ti) m_pend = m_pend & ~low;
      m_pend = m_pend | rise;
      if (en_wr) m_en = en_din;
      if (e_te) begin
        m_epc = id_pc + 32'd4; m_cause = 8'h01; m_ker = 1;
      end else if (e_ti) begin
        m_epc = id_pc; m_cause = 8'h80 + 8'(sel); m_ker = 1;
      end else if (e_rt) begin
        m_ker = 0;
      end
      @(posedge clk); #1;
      chk("rnd_ker",     {31'b0, ker},     {31'b0, m_ker});
      chk("rnd_pending", {28'b0, pending}, {28'b0, m_pend});
      chk("rnd_epc",     epc,              m_epc);
      chk("rnd_cause",   {24'b0, cause},   {24'b0, m_cause});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
